// File: rtl/i_type_controller_pkg.sv
// Shared opcode/ALU-op encodings and the FSM state type for the I-type
// controller slice.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    EXECUTE,
    WRITEBACK
  } ctrl_state_t;

endpackage

// File: rtl/i_type_controller_if.sv
// Instruction handshake plus datapath control bundle between a
// requester (master) and the I-type controller (slave).
interface i_type_controller_if #(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
);
  logic             instr_valid;
  logic [N-1:0]     instr;
  logic             instr_ready;
  logic [N-1:0]     instr_reg;
  logic [3:0]       alu_op;
  logic             reg_write;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [CNT_W-1:0] retired_count;

  modport master (
    output instr_valid, instr,
    input  instr_ready, instr_reg, alu_op, reg_write, busy, done, illegal,
           retired_count
  );

  modport slave (
    input  instr_valid, instr,
    output instr_ready, instr_reg, alu_op, reg_write, busy, done, illegal,
           retired_count
  );
endinterface

// File: rtl/i_type_controller_decoder.sv
// Combinational opcode decoder: maps a 6-bit I-type opcode to the ALU
// operation select and a legal-opcode flag.
module i_type_decoder
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  output logic [3:0] alu_op,
  output logic       legal
);

  always_comb begin
    alu_op = ALU_AND;
    legal  = 1'b1;
    case (opcode)
      OP_ADDI: alu_op = ALU_ADD;
      OP_ANDI: alu_op = ALU_AND;
      OP_ORI:  alu_op = ALU_OR;
      OP_SLTI: alu_op = ALU_SLT;
      default: legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/i_type_controller.sv
// Multi-cycle I-type sequencer: IDLE -> DECODE -> EXECUTE -> WRITEBACK,
// holding the instruction register and the retired-instruction counter.
module i_type_controller
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CNT_W = 16
) (
  input logic                clk,
  input logic                rst,
  i_type_controller_if.slave ctrl
);

  ctrl_state_t      state;
  logic [N-1:0]     instr_q;
  logic [3:0]       alu_op_q;
  logic             illegal_q;
  logic [CNT_W-1:0] count_q;

  logic [5:0] dec_opcode;
  logic [3:0] dec_op;
  logic       dec_legal;

  // In IDLE the decoder looks at the offered word so the illegal pulse can be
  // registered on the accepting edge; afterwards it decodes the held word.
  assign dec_opcode = (state == IDLE) ? ctrl.instr[31:26] : instr_q[31:26];

  i_type_decoder u_decoder (
    .opcode (dec_opcode),
    .alu_op (dec_op),
    .legal  (dec_legal)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      instr_q   <= '0;
      alu_op_q  <= ALU_AND;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (ctrl.instr_valid) begin
            instr_q   <= ctrl.instr;
            illegal_q <= ~dec_legal;
            state     <= DECODE;
          end
        end
        DECODE: begin
          if (dec_legal) begin
            alu_op_q <= dec_op;
            state    <= EXECUTE;
          end else begin
            state <= IDLE;
          end
        end
        EXECUTE: state <= WRITEBACK;
        WRITEBACK: begin
          alu_op_q <= ALU_AND;
          count_q  <= count_q + 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // A write to $0 is suppressed but the instruction still retires.
  assign ctrl.instr_ready   = (state == IDLE);
  assign ctrl.busy          = (state != IDLE);
  assign ctrl.done          = (state == WRITEBACK);
  assign ctrl.reg_write     = (state == WRITEBACK) && (instr_q[20:16] != 5'd0);
  assign ctrl.alu_op        = alu_op_q;
  assign ctrl.illegal       = illegal_q;
  assign ctrl.instr_reg     = instr_q;
  assign ctrl.retired_count = count_q;

endmodule

// File: tb/tb_i_type_controller.sv
// Bench for i_type_controller: a behavioural register file/ALU closes the
// loop, and an instruction-level reference model predicts every output.
module tb_i_type_controller;
  import mips_ctrl_pkg::*;

  localparam int unsigned N     = 32;
  localparam int unsigned CNT_W = 2;
  localparam int unsigned CMOD  = 1 << CNT_W;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i_type_controller_if #(.N(N), .CNT_W(CNT_W)) ifc ();
  i_type_controller #(.N(N), .CNT_W(CNT_W)) dut (
    .clk  (clk),
    .rst  (rst),
    .ctrl (ifc)
  );

  int tests = 0;
  int fails = 0;
  int exp_count = 0;
  logic [31:0] exp_regs [32] = '{default: '0};

  // Datapath stand-in: register file (no hardwired $0) plus ALU
  logic [31:0] regs [32] = '{default: '0};
  int unsigned writes = 0;

  function automatic logic [31:0] dp_alu(input logic [3:0] op, input logic [31:0] a,
                                         input logic [15:0] imm);
    logic [31:0] b;
    b = (op == ALU_AND || op == ALU_OR) ? {16'h0, imm} : {{16{imm[15]}}, imm};
    case (op)
      ALU_AND: return a & b;
      ALU_OR:  return a | b;
      ALU_ADD: return a + b;
      ALU_SLT: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  always @(posedge clk) begin
    if (ifc.reg_write) begin
      regs[ifc.instr_reg[20:16]] <= dp_alu(ifc.alu_op, regs[ifc.instr_reg[25:21]],
                                           ifc.instr_reg[15:0]);
      writes <= writes + 1;
    end
  end

  // Reference model: instruction semantics straight from the MIPS definitions
  function automatic logic [31:0] ref_result(input logic [5:0] op, input logic [31:0] rsv,
                                             input logic [15:0] imm);
    int signed s_rs, s_imm;
    s_rs  = int'($signed(rsv));
    s_imm = int'($signed(imm));
    if (op == OP_ADDI) return rsv + 32'(s_imm);
    if (op == OP_ANDI) return rsv & {16'h0, imm};
    if (op == OP_ORI)  return rsv | {16'h0, imm};
    return (s_rs < s_imm) ? 32'd1 : 32'd0;
  endfunction

  function automatic bit ref_legal(input logic [5:0] op);
    return op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010;
  endfunction

  function automatic logic [3:0] ref_op(input logic [5:0] op);
    if (op == 6'b001000) return 4'b0010;
    if (op == 6'b001100) return 4'b0000;
    if (op == 6'b001101) return 4'b0001;
    return 4'b0111;
  endfunction

  function automatic logic [31:0] mk(input logic [5:0] op, input int rs, input int rt,
                                     input logic [15:0] imm);
    return {op, 5'(rs), 5'(rt), imm};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction and checks every cycle until it leaves the controller.
  task automatic issue(input logic [31:0] ins, input bit expect_now, input bit hold_valid);
    int waits;
    logic [5:0] op;
    int rs, rt;
    bit legal;
    logic [3:0] eop;
    int unsigned writes0;
    op = ins[31:26]; rs = int'(ins[25:21]); rt = int'(ins[20:16]);
    legal = ref_legal(op);
    eop = ref_op(op);
    waits = 0;
    ifc.instr = ins;
    ifc.instr_valid = 1'b1;
    while (!ifc.instr_ready && waits < 16) begin
      tick();
      waits++;
    end
    tests++;
    if (waits >= 16 || (expect_now && waits != 0)) begin
      fails++;
      $display("FAIL accept %08h: waited %0d cycles, required %0d", ins, waits,
               expect_now ? 0 : 15);
      if (waits >= 16) return;
    end
    writes0 = writes;
    tick();  // DECODE
    ifc.instr = $urandom();
    if (!hold_valid) ifc.instr_valid = 1'b0;
    tests++;
    if (ifc.illegal !== !legal || ifc.busy !== 1'b1 || ifc.alu_op !== 4'b0000 ||
        ifc.reg_write !== 1'b0 || ifc.instr_reg !== ins) begin
      fails++;
      $display("FAIL decode %08h: illegal=%b busy=%b alu_op=%b rw=%b ir=%08h, required %b 1 0000 0 %08h",
               ins, ifc.illegal, ifc.busy, ifc.alu_op, ifc.reg_write, ifc.instr_reg, !legal, ins);
    end
    if (!legal) begin
      tick();
      tests++;
      if (ifc.instr_ready !== 1'b1 || ifc.illegal !== 1'b0 || writes != writes0 ||
          ifc.retired_count !== CNT_W'(exp_count)) begin
        fails++;
        $display("FAIL illegal_drop %08h: ready=%b illegal=%b writes=%0d cnt=%0d, required 1 0 %0d %0d",
                 ins, ifc.instr_ready, ifc.illegal, writes - writes0, ifc.retired_count, 0, exp_count);
      end
      return;
    end
    ifc.instr = $urandom();
    tick();  // EXECUTE
    tests++;
    if (ifc.alu_op !== eop || ifc.reg_write !== 1'b0 || ifc.done !== 1'b0 ||
        ifc.instr_reg !== ins) begin
      fails++;
      $display("FAIL execute %08h: alu_op=%b rw=%b done=%b ir=%08h, required %b 0 0 %08h",
               ins, ifc.alu_op, ifc.reg_write, ifc.done, ifc.instr_reg, eop, ins);
    end
    ifc.instr = $urandom();
    tick();  // WRITEBACK
    tests++;
    if (ifc.alu_op !== eop || ifc.reg_write !== (rt != 0) || ifc.done !== 1'b1 ||
        ifc.retired_count !== CNT_W'(exp_count) || ifc.instr_reg !== ins) begin
      fails++;
      $display("FAIL writeback %08h: alu_op=%b rw=%b done=%b cnt=%0d, required %b %b 1 %0d",
               ins, ifc.alu_op, ifc.reg_write, ifc.done, ifc.retired_count, eop, rt != 0, exp_count);
    end
    if (rt != 0) exp_regs[rt] = ref_result(op, exp_regs[rs], ins[15:0]);
    exp_count = (exp_count + 1) % CMOD;
    tick();  // back in IDLE
    tests++;
    if (ifc.instr_ready !== 1'b1 || ifc.done !== 1'b0 || ifc.reg_write !== 1'b0 ||
        ifc.alu_op !== 4'b0000 || ifc.retired_count !== CNT_W'(exp_count) ||
        regs[rt] !== exp_regs[rt] || regs[0] !== 32'd0 || ifc.instr_reg !== ins) begin
      fails++;
      $display("FAIL retire %08h: ready=%b done=%b rw=%b alu_op=%b cnt=%0d R%0d=%08h R0=%08h, required 1 0 0 0000 %0d %08h 0",
               ins, ifc.instr_ready, ifc.done, ifc.reg_write, ifc.alu_op, ifc.retired_count,
               rt, regs[rt], regs[0], exp_count, exp_regs[rt]);
    end
  endtask

  task automatic test_reset();
    ifc.instr_valid = 1'b0;
    ifc.instr = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if (ifc.instr_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.alu_op !== 4'b0000 ||
        ifc.reg_write !== 1'b0 || ifc.done !== 1'b0 || ifc.illegal !== 1'b0 ||
        ifc.retired_count !== '0 || ifc.instr_reg !== '0) begin
      fails++;
      $display("FAIL reset_values: ready=%b busy=%b alu_op=%b rw=%b done=%b ill=%b cnt=%0d ir=%08h, required 1 0 0000 0 0 0 0 0",
               ifc.instr_ready, ifc.busy, ifc.alu_op, ifc.reg_write, ifc.done, ifc.illegal,
               ifc.retired_count, ifc.instr_reg);
    end
    exp_count = 0;
  endtask

  task automatic test_single_addi();
    issue(32'h2010_0014, 1'b1, 1'b0);
    tests++;
    if (regs[16] !== 32'd20) begin
      fails++;
      $display("FAIL addi_r16: got %0d, required 20", regs[16]);
    end
  endtask

  task automatic test_back_to_back();
    issue(mk(OP_ADDI, 0, 8, 16'd5), 1'b0, 1'b0);
    issue(mk(OP_ANDI, 8, 10, 16'h00FF), 1'b0, 1'b1);
    issue(mk(OP_ORI, 8, 11, 16'hF0F0), 1'b1, 1'b1);
    issue(32'h2909_FFFF, 1'b1, 1'b0);
    tests++;
    if (regs[9] !== 32'd0 || regs[11] !== 32'h0000_F0F5 || regs[10] !== 32'd5) begin
      fails++;
      $display("FAIL sequence_regs: R9=%08h R10=%08h R11=%08h, required 0 5 f0f5",
               regs[9], regs[10], regs[11]);
    end
  endtask

  task automatic test_illegal();
    issue({6'b111111, 5'd1, 5'd2, 16'h1234}, 1'b0, 1'b0);
  endtask

  task automatic test_write_zero();
    int unsigned w0;
    w0 = writes;
    issue(mk(OP_ADDI, 1, 0, 16'd7), 1'b0, 1'b0);
    tests++;
    if (writes != w0 || regs[0] !== 32'd0) begin
      fails++;
      $display("FAIL write_zero: writes=%0d R0=%08h, required 0 0", writes - w0, regs[0]);
    end
  endtask

  task automatic test_wrap();
    int c0;
    c0 = int'(ifc.retired_count);
    for (int i = 0; i < 5; i++)
      issue(mk(OP_ORI, $urandom_range(0, 31), $urandom_range(1, 31), 16'($urandom)), 1'b0, 1'b0);
    tests++;
    if (ifc.retired_count !== CNT_W'((c0 + 5) % CMOD)) begin
      fails++;
      $display("FAIL wrap_count: got %0d, required %0d", ifc.retired_count, (c0 + 5) % CMOD);
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [4];
    logic [5:0] op;
    ops[0] = OP_ADDI; ops[1] = OP_ANDI; ops[2] = OP_ORI; ops[3] = OP_SLTI;
    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 4) == 0) begin
        op = 6'($urandom_range(0, 63));
        while (ref_legal(op)) op = 6'($urandom_range(0, 63));
      end else begin
        op = ops[$urandom_range(0, 3)];
      end
      issue(mk(op, $urandom_range(0, 31), $urandom_range(0, 31), 16'($urandom)),
            1'b0, $urandom_range(0, 1) == 1 && i != 23);
    end
  endtask

  task automatic test_reset_abort();
    int unsigned w0;
    logic [31:0] r5;
    issue(mk(OP_ADDI, 0, 5, 16'd1), 1'b0, 1'b0);
    r5 = regs[5];
    w0 = writes;
    ifc.instr = mk(OP_ADDI, 0, 5, 16'd123);
    ifc.instr_valid = 1'b1;
    tick();
    ifc.instr_valid = 1'b0;
    tick();  // EXECUTE
    #2 rst = 1'b0;
    #1;
    tests++;
    if (ifc.instr_ready !== 1'b1 || ifc.busy !== 1'b0 || ifc.alu_op !== 4'b0000 ||
        ifc.reg_write !== 1'b0 || ifc.done !== 1'b0 || ifc.retired_count !== '0 ||
        ifc.instr_reg !== '0) begin
      fails++;
      $display("FAIL reset_abort: ready=%b busy=%b alu_op=%b rw=%b done=%b cnt=%0d ir=%08h, required 1 0 0000 0 0 0 0",
               ifc.instr_ready, ifc.busy, ifc.alu_op, ifc.reg_write, ifc.done,
               ifc.retired_count, ifc.instr_reg);
    end
    exp_count = 0;
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if (ifc.instr_ready !== 1'b1 || writes != w0 || regs[5] !== r5) begin
      fails++;
      $display("FAIL reset_release: ready=%b writes=%0d R5=%08h, required 1 0 %08h",
               ifc.instr_ready, writes - w0, regs[5], r5);
    end
  endtask

  initial begin
    test_reset();
    test_single_addi();
    test_back_to_back();
    test_illegal();
    test_write_zero();
    test_wrap();
    test_random();
    test_reset_abort();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/i_type_controller.md
# i_type_controller

Multi-cycle sequencer for the 32-bit MIPS I-type ALU datapath (register file plus ALU). Accepts one instruction at a time over a valid/ready handshake, holds it in an instruction register, decodes the opcode, and drives the datapath's `ALU_OP` and `RegWrite` controls through a fixed DECODE/EXECUTE/WRITEBACK sequence. It also flags illegal opcodes and counts retired instructions.

## Interface
- `N`, 32: instruction and datapath width.
- `CNT_W`, 16: width of the retired-instruction counter.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset; asynchronous assertion, active-low.
- `instr_valid`  in  1  an instruction is offered on `instr`.
- `instr`  in  N  instruction word: opcode[31:26], rs[25:21], rt[20:16], imm[15:0].
- `instr_ready`  out  1  the controller can accept an instruction.
- `instr_reg`  out  N  held instruction, wired to the datapath's instruction input.
- `alu_op`  out  4  ALU operation select for the datapath.
- `reg_write`  out  1  register file write enable.
- `busy`  out  1  an instruction is in flight (any state other than IDLE).
- `done`  out  1  one-cycle pulse when an instruction retires.
- `illegal`  out  1  one-cycle pulse when an unsupported opcode is dropped.
- `retired_count`  out  CNT_W  count of retired instructions; wraps at 2^CNT_W.

## Operation
- **States:** IDLE, DECODE, EXECUTE, WRITEBACK.
- **Decode map:**
  - addi 6'b001000 → ADD 4'b0010
  - andi 6'b001100 → AND 4'b0000
  - ori 6'b001101 → OR 4'b0001
  - slti 6'b001010 → SLT 4'b0111
  - Any other opcode is illegal.
- **IDLE:**
  - `instr_ready`=1.
  - On `instr_valid`&&`instr_ready`, capture `instr` into `instr_reg` and go to DECODE.
- **DECODE:**
  - Register the decoded ALU op and legal flag.
  - Legal: go to EXECUTE.
  - Illegal: pulse `illegal` for one cycle, go to IDLE; no write, no count.
- **EXECUTE:** drive `alu_op` and let the datapath settle; `reg_write`=0.
- **WRITEBACK:**
  - `alu_op` stays at the same value.
  - `reg_write`=1 for exactly this cycle, unless rt==0; a write to $0 is suppressed but the instruction still retires.
  - Pulse `done`, increment `retired_count`, go to IDLE.
- **Gating:**
  - `instr_reg` changes only on an accepted handshake.
  - `instr` and `instr_valid` are ignored while `busy`=1.
- **Defaults outside EXECUTE/WRITEBACK:** `alu_op`=4'b0000, `reg_write`=0.
- **Reset values:**
  - state IDLE, `instr_reg`=0, `alu_op`=4'b0000.
  - `reg_write`=0, `done`=0, `illegal`=0, `busy`=0.
  - `retired_count`=0, `instr_ready`=1.
- **Reset mid-instruction:** abort immediately. No write is issued, the counter clears, and `instr_reg` clears.

## Timing
- Handshake accepted in cycle T → DECODE in T+1, EXECUTE in T+2, WRITEBACK in T+3 (`reg_write`=1, `done`=1).
- Back in IDLE at T+4 with `instr_ready`=1.
- Sustained throughput: one instruction per 4 cycles.
- Illegal opcode: `illegal`=1 in T+1, `instr_ready`=1 again in T+2.
- `instr_ready`, `busy` and `reg_write` are decoded from the state register. No combinational path runs from `instr_valid` to any output.
- `alu_op` and `reg_write` change only on clock edges or on reset assertion. The register file write lands on the rising edge that ends WRITEBACK.
- `retired_count` updates on the edge leaving WRITEBACK. At all-ones it wraps to 0, with `done` still pulsing.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the opcode constants (OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI);
  - the ALU op constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SLT);
  - the state enum `ctrl_state_t`.
- Sub-module `i_type_decoder`: purely combinational, maps opcode[5:0] → {alu_op[3:0], legal}.
- The controller instantiates `i_type_decoder` and owns the FSM, instruction register and counter.
- The top-level integration connects the controller to the existing register file and ALU in place of testbench-driven controls.

## Test plan
1. **Reset:** assert `rst`=0 mid-EXECUTE of an addi, then release → all outputs at reset values, no write observed, `instr_ready`=1 one cycle after release.
2. **Single addi:** addi R16,R0,20 (0x20100014) → `alu_op`=0010 in T+2/T+3, `reg_write`=1 only in T+3, R16=20 afterwards, `retired_count`=1.
3. **Sequence:** andi, ori, slti (slti R9,R8,-1 with R8=5) back-to-back, `instr_valid` held high → accepted every 4 cycles, `alu_op` 0000/0001/0111 respectively, R9=0, `retired_count`=3.
4. **Illegal opcode:** opcode 6'b111111 → `illegal` pulse in T+1, no `reg_write`, count unchanged, `instr_ready`=1 in T+2.
5. **Write to $0:** addi R0,R1,7 → `reg_write` stays 0, `done`=1, count increments, R0 reads 0.
6. **Gating and wrap:** with CNT_W=2, retire 5 instructions → count reads 1; changing `instr` while `busy`=1 leaves `instr_reg` unchanged.
